// File: rtl/roc_sim_bank.sv
// roc_sim_bank: simulation model of the TRNG ring-oscillator bank.
// N_RO free-running square waves with per-channel half-periods, optional
// LFSR-driven jitter and fault-injection modes (stuck-at, pair-locked).
module roc_sim_bank #(
    parameter int          N_RO        = 8,
    parameter int          PERIOD_BASE = 5,
    parameter int          JITTER_BITS = 2,
    parameter logic [31:0] SEED        = 32'hACE1_2468
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            jitter_en,
    input  logic [1:0]      mode,
    output logic [N_RO-1:0] ro
);

    // Largest value ever loaded into a channel counter.
    localparam int MAX_RELOAD = PERIOD_BASE + N_RO - 1 + (1 << JITTER_BITS) - 1;
    localparam int CW         = $clog2(MAX_RELOAD + 1);
    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] POLY     = 32'h8020_0003;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_STUCK0 = 2'b01;
    localparam logic [1:0] MODE_STUCK1 = 2'b10;
    localparam logic [1:0] MODE_PAIR   = 2'b11;

    // Illegal parameter sets stop elaboration.
    generate
        if (N_RO < 2 || (N_RO % 2) != 0 || PERIOD_BASE < 1 ||
            JITTER_BITS < 1 || JITTER_BITS > 4 || N_RO * JITTER_BITS > 32) begin : g_bad_params
            $fatal(1, "roc_sim_bank: illegal parameter combination");
        end
    endgenerate

    logic [31:0]            lfsr;
    logic [31:0]            lfsr_next;
    logic [CW-1:0]          cnt    [N_RO];
    logic [CW-1:0]          reload [N_RO];
    logic [JITTER_BITS-1:0] jit    [N_RO];
    logic [N_RO-1:0]        osc;
    logic [N_RO-1:0]        ro_next;

    // Galois right-shift step of the jitter LFSR.
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
    end

    // Reload value per channel; jitter uses the pre-advance LFSR value.
    always_comb begin
        for (int i = 0; i < N_RO; i++) begin
            jit[i]    = jitter_en ? lfsr[i*JITTER_BITS +: JITTER_BITS] : '0;
            reload[i] = CW'(PERIOD_BASE) + CW'(i) + CW'(jit[i]);
        end
    end

    // LFSR advances only on enabled edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else if (en) begin
            lfsr <= lfsr_next;
        end
    end

    // Per-channel down-counter and phase bit; toggle and reload at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            osc <= '0;
            for (int i = 0; i < N_RO; i++) begin
                cnt[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < N_RO; i++) begin
                if (cnt[i] == '0) begin
                    osc[i] <= ~osc[i];
                    cnt[i] <= reload[i];
                end else begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Output view selected by mode; oscillator state is never touched here.
    always_comb begin
        ro_next = osc;
        case (mode)
            MODE_NORMAL: ro_next = osc;
            MODE_STUCK0: ro_next = '0;
            MODE_STUCK1: ro_next = '1;
            MODE_PAIR: begin
                for (int k = 0; k < N_RO / 2; k++) begin
                    ro_next[2*k]   = osc[2*k];
                    ro_next[2*k+1] = osc[2*k];
                end
            end
            default: ro_next = osc;
        endcase
    end

    // Output register updates every edge regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro <= '0;
        end else begin
            ro <= ro_next;
        end
    end

endmodule

// File: tb/tb_roc_sim_bank.sv
// tb_roc_sim_bank: randomized self-checking bench for roc_sim_bank against
// an event-time reference model (toggle times in enabled steps).
module tb_roc_sim_bank;

    localparam int          N   = 4;
    localparam int          PB  = 5;
    localparam int          JB  = 2;
    localparam logic [31:0] SD  = 32'h0;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         jitter_en;
    logic [1:0]   mode;
    logic [N-1:0] ro;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state: level per channel, enabled-step index of the
    // next toggle, enabled-step counter, LFSR, and the expected output.
    logic [N-1:0] lvl;
    int           nxt [N];
    int           t;
    logic [31:0]  lf;
    logic [N-1:0] exp_ro;

    roc_sim_bank #(
        .N_RO(N), .PERIOD_BASE(PB), .JITTER_BITS(JB), .SEED(SD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .jitter_en(jitter_en),
        .mode(mode), .ro(ro)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model with the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_ro = '0;
            lvl    = '0;
            for (int i = 0; i < N; i++) nxt[i] = 0;
            t  = 0;
            lf = (SD == 32'h0) ? 32'h1 : SD;
        end else begin
            case (mode)
                2'b00: exp_ro = lvl;
                2'b01: exp_ro = '0;
                2'b10: exp_ro = '1;
                default: exp_ro = {lvl[2], lvl[2], lvl[0], lvl[0]};
            endcase
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    if (t == nxt[i]) begin
                        lvl[i] = ~lvl[i];
                        nxt[i] = t + PB + i + 1 +
                                 (jitter_en ? int'((lf >> (i*JB)) & ((1 << JB) - 1)) : 0);
                    end
                end
                lf = lf[0] ? ((lf >> 1) ^ POLY) : (lf >> 1);
                t++;
            end
        end
        cyc++;
        #1;
    endtask

    // Apply a one-cycle reset and release it with en=1, mode 00.
    task automatic do_reset(input logic jit);
        rst = 1'b1; en = 1'b1; jitter_en = jit; mode = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; jitter_en = 1'b0; mode = 2'b10;
        step();
        vectors++;
        if (ro !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_overrides_mode ro=%b expected=%b", ro, 4'b0000);
        end
        mode = 2'b00;
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (ro !== 4'b0000) begin
            miscompares++;
            $display("FAIL first_edge_low ro=%b expected=%b", ro, 4'b0000);
        end
        step();
        vectors++;
        if (ro !== 4'b1111) begin
            miscompares++;
            $display("FAIL first_edge_high ro=%b expected=%b", ro, 4'b1111);
        end
    endtask

    task automatic test_period();
        int           last [N];
        logic [N-1:0] prev;
        prev = ro;
        for (int i = 0; i < N; i++) last[i] = cyc;
        for (int c = 0; c < 80; c++) begin
            step();
            vectors++;
            if (ro !== exp_ro) begin
                miscompares++;
                $display("FAIL period_model cyc=%0d ro=%b expected=%b", cyc, ro, exp_ro);
            end
            for (int i = 0; i < N; i++) begin
                if (ro[i] !== prev[i]) begin
                    vectors++;
                    if (cyc - last[i] != PB + i + 1) begin
                        miscompares++;
                        $display("FAIL period_ch%0d interval=%0d expected=%0d", i, cyc - last[i], PB + i + 1);
                    end
                    last[i] = cyc;
                end
            end
            prev = ro;
        end
    endtask

    task automatic test_jitter();
        int cnt;
        do_reset(1'b1);
        step();
        step();
        cnt = 0;
        while (ro[0] === 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        vectors++;
        if (cnt != 7) begin
            miscompares++;
            $display("FAIL jitter_first_high len=%0d expected=%0d", cnt, 7);
        end
        for (int c = 0; c < 1000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) jitter_en = ~jitter_en;
            step();
            vectors++;
            if (ro !== exp_ro) begin
                miscompares++;
                $display("FAIL jitter_model cyc=%0d ro=%b expected=%b", cyc, ro, exp_ro);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_stall();
        logic [N-1:0] hold;
        do_reset(1'b0);
        for (int c = 0; c < 23; c++) step();
        en = 1'b0;
        step();
        hold = exp_ro;
        for (int c = 0; c < 9; c++) begin
            step();
            vectors++;
            if (ro !== hold) begin
                miscompares++;
                $display("FAIL stall_frozen cyc=%0d ro=%b expected=%b", cyc, ro, hold);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            vectors++;
            if (ro !== exp_ro) begin
                miscompares++;
                $display("FAIL stall_resume cyc=%0d ro=%b expected=%b", cyc, ro, exp_ro);
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0] seq [4];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b00;
        do_reset(1'b1);
        for (int m = 0; m < 4; m++) begin
            mode = seq[m];
            step();
            vectors++;
            if ((m == 1 && ro !== 4'b0000) || (m == 2 && ro !== 4'b1111)) begin
                miscompares++;
                $display("FAIL mode_switch m=%b ro=%b", seq[m], ro);
            end
            for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
                en = ($urandom_range(0, 7) != 0);
                step();
                vectors++;
                if (ro !== exp_ro) begin
                    miscompares++;
                    $display("FAIL mode_model cyc=%0d mode=%b ro=%b expected=%b", cyc, mode, ro, exp_ro);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_pair_lock();
        mode = 2'b11;
        for (int c = 0; c < 150; c++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
            vectors++;
            if (c > 0 && (ro[1] !== ro[0] || ro[3] !== ro[2])) begin
                miscompares++;
                $display("FAIL pair_equal cyc=%0d ro=%b", cyc, ro);
            end
            vectors++;
            if (ro !== exp_ro) begin
                miscompares++;
                $display("FAIL pair_model cyc=%0d ro=%b expected=%b", cyc, ro, exp_ro);
            end
        end
        en = 1'b1;
        mode = 2'b00;
    endtask

    task automatic test_mid_reset();
        do_reset(1'b1);
        for (int c = 0; c < 37; c++) step();
        rst = 1'b1;
        step();
        vectors++;
        if (ro !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_zero ro=%b expected=%b", ro, 4'b0000);
        end
        rst = 1'b0;
        step();
        step();
        vectors++;
        if (ro !== 4'b1111) begin
            miscompares++;
            $display("FAIL mid_reset_restart ro=%b expected=%b", ro, 4'b1111);
        end
        for (int c = 0; c < 200; c++) begin
            step();
            vectors++;
            if (ro !== exp_ro) begin
                miscompares++;
                $display("FAIL mid_reset_model cyc=%0d ro=%b expected=%b", cyc, ro, exp_ro);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; jitter_en = 1'b0; mode = 2'b00;
        lvl = '0; t = 0; lf = 32'h1; exp_ro = '0;
        for (int i = 0; i < N; i++) nxt[i] = 0;
        test_reset();
        test_period();
        test_jitter();
        test_stall();
        test_modes();
        test_pair_lock();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
